// File: rtl/sargantana_icache_pkg.sv
// Shared icache types: way-controller FSM states and default array geometry.
package sargantana_icache_pkg;

   localparam int unsigned ICACHE_SET_WIDTH  = 256;
   localparam int unsigned ICACHE_ADDR_WIDTH = 6;
   localparam int unsigned ICACHE_NUM_WAYS   = 4;
   localparam int unsigned ICACHE_NUM_SETS   = 2 ** ICACHE_ADDR_WIDTH;

   typedef enum logic {
      IDLE,
      FLUSH
   } icache_way_state_t;

endpackage

// File: rtl/sargantana_icache_way_ctrl_if.sv
// Pin bundle between the way controller and the way SRAM instances.
interface sargantana_icache_way_ctrl_if
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned SET_WIDTH  = ICACHE_SET_WIDTH,
   parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
   parameter int unsigned NUM_WAYS   = ICACHE_NUM_WAYS
);
   logic [NUM_WAYS-1:0]           req;
   logic [NUM_WAYS-1:0]           we;
   logic [ADDR_WIDTH-1:0]         addr;
   logic [SET_WIDTH-1:0]          wdata;
   logic [NUM_WAYS*SET_WIDTH-1:0] rdata;

   modport master (output req, output we, output addr, output wdata, input rdata);
   modport slave  (input req, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/sargantana_icache_way_flush_cnt.sv
// Flush sweep set counter: loads zero on start, steps once per enabled cycle.
module sargantana_icache_way_flush_cnt #(
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  en_i,
   output logic [ADDR_WIDTH-1:0] count_o,
   output logic                  last_o
);
   logic [ADDR_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (start_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = &count_q;
endmodule

// File: rtl/sargantana_icache_way_ctrl.sv
// Arbitrates fetch reads, refill writes and a full-array flush sweep onto the way SRAMs.
// One SRAM operation per cycle; grants are combinational, read data returns one cycle later.
module sargantana_icache_way_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned SET_WIDTH  = ICACHE_SET_WIDTH,
   parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
   parameter int unsigned NUM_WAYS   = ICACHE_NUM_WAYS
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          fetch_req_i,
   input  logic [ADDR_WIDTH-1:0]         fetch_addr_i,
   output logic                          fetch_gnt_o,
   output logic                          fetch_rvalid_o,
   output logic [NUM_WAYS*SET_WIDTH-1:0] fetch_rdata_o,
   input  logic                          refill_req_i,
   input  logic [NUM_WAYS-1:0]           refill_way_i,
   input  logic [ADDR_WIDTH-1:0]         refill_addr_i,
   input  logic [SET_WIDTH-1:0]          refill_data_i,
   output logic                          refill_gnt_o,
   input  logic                          flush_i,
   output logic                          flush_done_o,
   output logic                          busy_o,
   sargantana_icache_way_ctrl_if.master  way_o
);
   icache_way_state_t     state_q, state_d;
   logic                  last_refill_q, last_refill_d;
   logic                  rvalid_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SET_WIDTH-1:0]  wdata_q, wdata_d;
   logic [NUM_WAYS-1:0]   req_d, we_d;
   logic                  cnt_start, cnt_en, cnt_last;
   logic [ADDR_WIDTH-1:0] cnt;

   sargantana_icache_way_flush_cnt #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (cnt_start),
      .en_i    (cnt_en),
      .count_o (cnt),
      .last_o  (cnt_last)
   );

   always_comb begin
      state_d       = state_q;
      fetch_gnt_o   = 1'b0;
      refill_gnt_o  = 1'b0;
      flush_done_o  = 1'b0;
      busy_o        = 1'b0;
      cnt_start     = 1'b0;
      cnt_en        = 1'b0;
      req_d         = '0;
      we_d          = '0;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      unique case (state_q)
         IDLE: begin
            // A refill in the previous cycle yields to a waiting fetch once.
            if (refill_req_i && !(last_refill_q && fetch_req_i)) begin
               refill_gnt_o = 1'b1;
               req_d        = refill_way_i;
               we_d         = refill_way_i;
               addr_d       = refill_addr_i;
               wdata_d      = refill_data_i;
            end else if (fetch_req_i) begin
               fetch_gnt_o  = 1'b1;
               req_d        = '1;
               addr_d       = fetch_addr_i;
            end
            if (flush_i) begin
               state_d   = FLUSH;
               cnt_start = 1'b1;
            end
         end
         FLUSH: begin
            busy_o  = 1'b1;
            cnt_en  = 1'b1;
            req_d   = '1;
            we_d    = '1;
            addr_d  = cnt;
            wdata_d = '0;
            if (cnt_last) begin
               flush_done_o = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      last_refill_d = refill_gnt_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         last_refill_q <= 1'b0;
         rvalid_q      <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         last_refill_q <= last_refill_d;
         rvalid_q      <= fetch_gnt_o;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
      end
   end

   assign way_o.req      = req_d;
   assign way_o.we       = we_d;
   assign way_o.addr     = addr_d;
   assign way_o.wdata    = wdata_d;
   assign fetch_rvalid_o = rvalid_q;
   assign fetch_rdata_o  = way_o.rdata;

   a_refill_way_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      refill_req_i |-> $onehot(refill_way_i));
endmodule

// File: tb/tb_sargantana_icache_way_ctrl.sv
// Bench for the icache way controller: behavioural arbitration/memory model plus directed scenarios.
module tb_sargantana_icache_way_ctrl;
   import sargantana_icache_pkg::*;

   localparam int SW    = 256;
   localparam int AW    = 6;
   localparam int NW    = 4;
   localparam int NSETS = ICACHE_NUM_SETS;

   logic clk = 1'b0;
   logic rst, fetch_req, refill_req, flush, fetch_gnt, refill_gnt, rvalid, done, busy;
   logic [AW-1:0]    fetch_addr, refill_addr;
   logic [NW-1:0]    refill_way;
   logic [SW-1:0]    refill_data;
   logic [NW*SW-1:0] rdata;

   int checks = 0;
   int errors = 0;

   sargantana_icache_way_ctrl_if #(.SET_WIDTH(SW), .ADDR_WIDTH(AW), .NUM_WAYS(NW)) way_bus ();

   sargantana_icache_way_ctrl #(.SET_WIDTH(SW), .ADDR_WIDTH(AW), .NUM_WAYS(NW)) dut (
      .clk_i(clk), .rst_i(rst),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
      .fetch_rvalid_o(rvalid), .fetch_rdata_o(rdata),
      .refill_req_i(refill_req), .refill_way_i(refill_way), .refill_addr_i(refill_addr),
      .refill_data_i(refill_data), .refill_gnt_o(refill_gnt),
      .flush_i(flush), .flush_done_o(done), .busy_o(busy),
      .way_o(way_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [SW-1:0] init_line(int w, int s);
      return {8{8'(w), 8'(s), 16'hC0DE}};
   endfunction

   // Way SRAMs: 1-cycle read latency, output holds when not read.
   logic [SW-1:0]    sram    [NW][NSETS];
   bit               sram_wr [NW][NSETS];
   logic [NW*SW-1:0] sram_q;
   always @(posedge clk) begin
      for (int w = 0; w < NW; w++) begin
         if (way_bus.req[w]) begin
            if (way_bus.we[w]) begin
               sram[w][way_bus.addr]    <= way_bus.wdata;
               sram_wr[w][way_bus.addr] <= 1'b1;
            end else begin
               sram_q[w*SW +: SW] <= sram_wr[w][way_bus.addr] ? sram[w][way_bus.addr]
                                                              : init_line(w, int'(way_bus.addr));
            end
         end
      end
   end
   assign way_bus.rdata = sram_q;

   task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h (low 64 bits)", name, act, exp);
      end
   endtask

   // Model: expected memory contents, sweep progress and arbitration history.
   logic [SW-1:0]    m_mem [NW][NSETS];
   bit               m_wr  [NW][NSETS];
   logic [NW*SW-1:0] m_read;
   bit               known = 1'b0;
   int               m_left, m_idx;
   bit               m_prev_refill, m_prev_fetch;
   logic [AW-1:0]    m_last_addr;
   logic [SW-1:0]    m_last_wdata;
   bit               e_fg, e_rg, e_busy, e_done;
   logic [NW-1:0]    e_req, e_we;
   logic [AW-1:0]    e_addr;
   logic [SW-1:0]    e_wdata;

   function automatic logic [SW-1:0] mget(int w, int a);
      return m_wr[w][a] ? m_mem[w][a] : init_line(w, a);
   endfunction

   task automatic model_reset();
      m_left = 0; m_idx = 0; m_prev_refill = 0; m_prev_fetch = 0;
      m_last_addr = '0; m_last_wdata = '0;
   endtask

   always @(negedge clk) begin
      if (!known) begin
         if (rst === 1'b1) begin
            known = 1'b1;
            model_reset();
         end
      end else begin
         e_fg = 0; e_rg = 0; e_busy = 0; e_done = 0; e_req = '0; e_we = '0;
         e_addr = m_last_addr; e_wdata = m_last_wdata;
         if (m_left > 0) begin
            e_busy = 1; e_req = '1; e_we = '1; e_addr = AW'(m_idx); e_wdata = '0;
            e_done = (m_left == 1);
         end else begin
            e_rg = refill_req && !(m_prev_refill && fetch_req);
            e_fg = fetch_req && !e_rg;
            if (e_rg) begin
               e_req = refill_way; e_we = refill_way; e_addr = refill_addr; e_wdata = refill_data;
            end else if (e_fg) begin
               e_req = '1; e_addr = fetch_addr;
            end
         end
         chkv("m_fetch_gnt", 64'(fetch_gnt), 64'(e_fg));
         chkv("m_refill_gnt", 64'(refill_gnt), 64'(e_rg));
         chkv("m_busy", 64'(busy), 64'(e_busy));
         chkv("m_flush_done", 64'(done), 64'(e_done));
         chkv("m_way_req", 64'(way_bus.req), 64'(e_req));
         chkv("m_way_we", 64'(way_bus.we), 64'(e_we));
         chkv("m_way_addr", 64'(way_bus.addr), 64'(e_addr));
         if (!e_fg) chk("m_way_wdata", way_bus.wdata === e_wdata, way_bus.wdata[63:0], e_wdata[63:0]);
         chkv("m_rvalid", 64'(rvalid), 64'(m_prev_fetch));
         if (m_prev_fetch) chk("m_rdata", rdata === m_read, rdata[63:0], m_read[63:0]);
         // advance the model by one clock
         if (m_left > 0) begin
            for (int w = 0; w < NW; w++) begin
               m_mem[w][m_idx] = '0; m_wr[w][m_idx] = 1;
            end
            m_last_addr = AW'(m_idx); m_last_wdata = '0;
            m_idx++; m_left--;
         end else begin
            if (e_rg) begin
               for (int w = 0; w < NW; w++) begin
                  if (refill_way[w]) begin
                     m_mem[w][refill_addr] = refill_data; m_wr[w][refill_addr] = 1;
                  end
               end
               m_last_addr = refill_addr; m_last_wdata = refill_data;
            end else if (e_fg) begin
               for (int w = 0; w < NW; w++) m_read[w*SW +: SW] = mget(w, int'(fetch_addr));
               m_last_addr = fetch_addr;
            end
            if (flush) begin
               m_left = NSETS; m_idx = 0;
            end
         end
         m_prev_refill = e_rg;
         m_prev_fetch  = e_fg;
         if (rst) model_reset();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0]   exp_w0 [3] = '{32'h0005C0DE, 32'h0006C0DE, 32'h0007C0DE};
   logic [31:0]   exp_w3 [3] = '{32'h0305C0DE, 32'h0306C0DE, 32'h0307C0DE};
   logic [SW-1:0] a5_line;
   logic [3:0]    rpat, fpat;
   int            nbusy, ngnt, ndone, done_cyc;
   bit            seen_idle;

   initial begin
      rst = 1; fetch_req = 0; refill_req = 0; flush = 0;
      fetch_addr = '0; refill_addr = '0; refill_way = '0; refill_data = '0;
      a5_line = {32{8'hA5}};
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chkv("rst_busy", 64'(busy), 0);
      chkv("rst_rvalid", 64'(rvalid), 0);
      chkv("rst_way_req", 64'(way_bus.req), 0);
      chkv("rst_way_we", 64'(way_bus.we), 0);
      chkv("rst_grants", 64'({fetch_gnt, refill_gnt}), 0);
      chkv("rst_done", 64'(done), 0);
      step();

      // back-to-back fetches of sets 5, 6, 7
      for (int i = 0; i < 4; i++) begin
         fetch_req = (i < 3); fetch_addr = AW'(5 + i);
         @(negedge clk);
         if (i < 3) chkv("seq_fetch_gnt", 64'(fetch_gnt), 1);
         if (i > 0) begin
            chkv("seq_rvalid", 64'(rvalid), 1);
            chkv("seq_rdata_w0", 64'(rdata[31:0]), 64'(exp_w0[i-1]));
            chkv("seq_rdata_w3", 64'(rdata[3*SW +: 32]), 64'(exp_w3[i-1]));
         end
         step();
      end
      fetch_req = 0;

      // refill way 2, set 9, then read it back
      refill_req = 1; refill_way = 4'b0100; refill_addr = 6'd9; refill_data = a5_line;
      @(negedge clk);
      chkv("refill_gnt", 64'(refill_gnt), 1);
      chkv("refill_way_we", 64'(way_bus.we), 64'(4'b0100));
      step();
      refill_req = 0; fetch_req = 1; fetch_addr = 6'd9;
      @(negedge clk);
      chkv("refill_rd_gnt", 64'(fetch_gnt), 1);
      step();
      fetch_req = 0;
      @(negedge clk);
      chk("refill_rd_w2", rdata[2*SW +: SW] === a5_line, rdata[2*SW +: 64], a5_line[63:0]);
      chkv("refill_rd_w1", 64'(rdata[1*SW +: 32]), 64'(32'h0109C0DE));
      chkv("refill_rd_w3", 64'(rdata[3*SW +: 32]), 64'(32'h0309C0DE));
      step();

      // refill and fetch both held: grants alternate starting with refill
      refill_req = 1; refill_way = 4'b0001; refill_addr = 6'd10; refill_data = {SW{1'b1}};
      fetch_req = 1; fetch_addr = 6'd11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rpat[i] = refill_gnt; fpat[i] = fetch_gnt;
         step();
      end
      refill_req = 0; fetch_req = 0;
      chkv("alt_refill_pattern", 64'(rpat), 64'(4'b0101));
      chkv("alt_fetch_pattern", 64'(fpat), 64'(4'b1010));
      step();

      // full flush with requests and a re-asserted flush during the sweep
      flush = 1;
      step();
      flush = 0;
      nbusy = 0; ngnt = 0; ndone = 0; done_cyc = 0; seen_idle = 0;
      refill_way = 4'b0001;
      for (int c = 1; c <= 100 && !seen_idle; c++) begin
         refill_req = (c >= 10 && c < 40); fetch_req = (c >= 10 && c < 40); flush = (c == 30);
         @(negedge clk);
         if (busy) begin
            nbusy++;
            if (fetch_gnt || refill_gnt) ngnt++;
            if (done) begin ndone++; done_cyc = c; end
         end else begin
            seen_idle = 1;
         end
         step();
      end
      refill_req = 0; fetch_req = 0; flush = 0;
      chkv("flush_busy_cycles", 64'(nbusy), 64);
      chkv("flush_done_cycle", 64'(done_cyc), 64);
      chkv("flush_done_count", 64'(ndone), 1);
      chkv("flush_grants", 64'(ngnt), 0);

      fetch_req = 1; fetch_addr = 6'd0;
      @(negedge clk);
      chkv("post_flush_gnt0", 64'(fetch_gnt), 1);
      step();
      fetch_addr = 6'd63;
      @(negedge clk);
      chk("post_flush_set0_zero", rdata === '0, rdata[63:0], 64'd0);
      step();
      fetch_req = 0;
      @(negedge clk);
      chkv("post_flush_rvalid63", 64'(rvalid), 1);
      chk("post_flush_set63_zero", rdata === '0, rdata[63:0], 64'd0);
      step();

      // fetch together with flush, then reset in sweep cycle 20
      fetch_req = 1; fetch_addr = 6'd3; flush = 1;
      @(negedge clk);
      chkv("fetch_with_flush_gnt", 64'(fetch_gnt), 1);
      step();
      fetch_req = 0; flush = 0;
      @(negedge clk);
      chkv("flush_c1_rvalid", 64'(rvalid), 1);
      chkv("flush_c1_busy", 64'(busy), 1);
      step();
      repeat (18) step();
      rst = 1;
      @(negedge clk);
      chkv("sweep20_busy", 64'(busy), 1);
      chkv("sweep20_addr", 64'(way_bus.addr), 19);
      step();
      rst = 0;
      @(negedge clk);
      chkv("abort_busy", 64'(busy), 0);
      chkv("abort_done", 64'(done), 0);
      chkv("abort_rvalid", 64'(rvalid), 0);
      chkv("abort_way_req", 64'(way_bus.req), 0);
      ndone = 0; nbusy = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
         step();
      end
      chkv("abort_no_done", 64'(ndone), 0);
      chkv("abort_no_busy", 64'(nbusy), 0);
      fetch_req = 1; fetch_addr = 6'd1;
      @(negedge clk);
      chkv("abort_fetch_gnt", 64'(fetch_gnt), 1);
      step();
      fetch_req = 0;
      @(negedge clk);
      chkv("abort_fetch_rvalid", 64'(rvalid), 1);
      chkv("abort_fetch_w2", 64'(rdata[2*SW +: 32]), 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
